// File: rtl/encoder32_5_drain_pkg.sv
// Shared constants and FSM state encoding for the 32-to-5 draining encoder.
package encoder32_5_drain_pkg;

    localparam int REQ_W = 32;
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage : encoder32_5_drain_pkg

// File: rtl/encoder32_5_drain_lsb_find32.sv
// Combinational lowest-set-bit finder: isolates the lowest set bit of vec and
// reports its binary index. idx reads 0 when vec is all zero (any = 0).
module lsb_find32
    import encoder32_5_drain_pkg::*;
(
    input  logic [REQ_W-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [REQ_W-1:0] onehot;
    logic [IDX_W-1:0] contrib [REQ_W];

    // Two's-complement trick keeps only the lowest set bit.
    assign onehot = vec & (~vec + REQ_W'(1));
    assign any    = |vec;

    generate
        for (genvar gi = 0; gi < REQ_W; gi++) begin : g_contrib
            assign contrib[gi] = onehot[gi] ? IDX_W'(gi) : '0;
        end
    endgenerate

    // At most one contribution is non-zero, so an OR-reduction yields the index.
    always_comb begin
        idx = '0;
        for (int i = 0; i < REQ_W; i++) begin
            idx = idx | contrib[i];
        end
    end

endmodule : lsb_find32

// File: rtl/encoder32_5_drain.sv
// Draining priority encoder: captures a multi-hot request vector and emits the
// indices of its set bits in ascending order over a valid/ready handshake.
module encoder32_5_drain
    import encoder32_5_drain_pkg::*;
#(
    parameter int REQ_W_P = REQ_W,
    parameter int IDX_W_P = IDX_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [REQ_W_P-1:0] req,
    output logic               busy,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [IDX_W_P-1:0] o_idx,
    output logic               o_last
);

    state_e             state_q,   state_d;
    logic [REQ_W_P-1:0] pending_q, pending_d;
    logic               valid_q,   valid_d;
    logic [IDX_W_P-1:0] idx_q,     idx_d;
    logic               last_q,    last_d;

    logic [IDX_W_P-1:0] lsb_idx;
    logic               lsb_any;
    logic [REQ_W_P-1:0] pending_cleared;

    lsb_find32 u_lsb (
        .vec (pending_q),
        .idx (lsb_idx),
        .any (lsb_any)
    );

    // Pending mask with the currently selected lowest bit removed.
    assign pending_cleared = pending_q & ~(REQ_W_P'(1) << lsb_idx);

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
        end
    end

    // Next-state logic: capture in IDLE, first grant in SCAN, back-to-back grants in HOLD.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        last_d    = last_q;
        unique case (state_q)
            IDLE: begin
                if (load && (req != '0)) begin
                    pending_d = req;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                idx_d     = lsb_idx;
                pending_d = pending_cleared;
                valid_d   = 1'b1;
                last_d    = (pending_cleared == '0);
                state_d   = HOLD;
            end
            HOLD: begin
                if (o_ready) begin
                    if (lsb_any) begin
                        idx_d     = lsb_idx;
                        pending_d = pending_cleared;
                        valid_d   = 1'b1;
                        last_d    = (pending_cleared == '0);
                    end else begin
                        idx_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
                valid_d   = 1'b0;
                idx_d     = '0;
                last_d    = 1'b0;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign o_valid = valid_q;
    assign o_idx   = idx_q;
    assign o_last  = last_q;

endmodule : encoder32_5_drain

// File: tb/tb_encoder32_5_drain.sv
// Directed bench for encoder32_5_drain: table of full-drain batches plus
// hand-written backpressure, ignored-load and reset sequences.
module tb_encoder32_5_drain;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] req;
    logic        busy;
    logic        o_valid;
    logic        o_ready;
    logic [4:0]  o_idx;
    logic        o_last;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    encoder32_5_drain dut (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .req     (req),
        .busy    (busy),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_idx   (o_idx),
        .o_last  (o_last)
    );

    typedef struct {
        logic [31:0] req;
        int          n_exp;
        int          first_exp;
        int          last_exp;
    } batch_t;

    batch_t vecs [5];

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lowest_bit(input logic [31:0] m);
        for (int b = 0; b < 32; b++) begin
            if (m[b]) return b;
        end
        return -1;
    endfunction

    // Load one batch with o_ready held high and follow it to completion.
    task automatic run_batch(input batch_t v);
        logic [31:0] m;
        int seen;
        int first_seen;
        int last_seen;
        int k;
        m = v.req;
        seen = 0;
        first_seen = -1;
        last_seen = -1;
        req = v.req; load = 1'b1; o_ready = 1'b1;
        step();
        load = 1'b0; req = 32'h0;
        check("latency_no_valid_yet", {31'b0, o_valid}, 32'd0);
        check("busy_in_scan", {31'b0, busy}, 32'd1);
        step();
        for (int i = 0; i < 32 && m != 32'h0; i++) begin
            k = lowest_bit(m);
            m[k] = 1'b0;
            $display("[TB] batch req=0x%08h idx=%0d last=%0b valid=%0b", v.req, o_idx, o_last, o_valid);
            check("batch_valid", {31'b0, o_valid}, 32'd1);
            check("batch_idx", {27'b0, o_idx}, k);
            check("batch_last", {31'b0, o_last}, {31'b0, (m == 32'h0)});
            if (o_valid) begin
                if (first_seen < 0) first_seen = int'(o_idx);
                last_seen = int'(o_idx);
                seen++;
            end
            step();
        end
        check("batch_count", seen, v.n_exp);
        check("batch_first", first_seen, v.first_exp);
        check("batch_lastidx", last_seen, v.last_exp);
        check("batch_end_valid", {31'b0, o_valid}, 32'd0);
        check("batch_end_idx", {27'b0, o_idx}, 32'd0);
        check("batch_end_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0001, 1, 0, 0};
        vecs[1] = '{32'h8000_0012, 3, 1, 31};
        vecs[2] = '{32'hFFFF_FFFF, 32, 0, 31};
        vecs[3] = '{32'h8000_0000, 1, 31, 31};
        vecs[4] = '{32'h0000_0400, 1, 10, 10};

        // Reset, with load and o_ready asserted to show reset wins.
        reset = 1'b1; load = 1'b1; req = 32'hFFFF_FFFF; o_ready = 1'b1;
        step(); step();
        reset = 1'b0; load = 1'b0; req = 32'h0;
        $display("[TB] reset valid=%0b idx=%0d last=%0b busy=%0b", o_valid, o_idx, o_last, busy);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_idx", {27'b0, o_idx}, 32'd0);
        check("rst_last", {31'b0, o_last}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 5; i++) run_batch(vecs[i]);

        // Backpressure: index 6 held for 3 cycles, then 7 right after release.
        req = 32'h0000_00C0; load = 1'b1; o_ready = 1'b0;
        step();
        load = 1'b0; req = 32'h0;
        step();
        for (int c = 0; c < 3; c++) begin
            $display("[TB] hold cycle=%0d idx=%0d valid=%0b last=%0b", c, o_idx, o_valid, o_last);
            check("bp_hold_valid", {31'b0, o_valid}, 32'd1);
            check("bp_hold_idx", {27'b0, o_idx}, 32'd6);
            check("bp_hold_last", {31'b0, o_last}, 32'd0);
            if (c < 2) step();
        end
        o_ready = 1'b1;
        step();
        $display("[TB] release idx=%0d valid=%0b last=%0b", o_idx, o_valid, o_last);
        check("bp_next_idx", {27'b0, o_idx}, 32'd7);
        check("bp_next_last", {31'b0, o_last}, 32'd1);
        step();
        check("bp_done_valid", {31'b0, o_valid}, 32'd0);
        check("bp_done_busy", {31'b0, busy}, 32'd0);

        // Load with req=0 in IDLE is ignored.
        req = 32'h0; load = 1'b1;
        step();
        load = 1'b0;
        step();
        $display("[TB] zero-load busy=%0b valid=%0b", busy, o_valid);
        check("zero_load_busy", {31'b0, busy}, 32'd0);
        check("zero_load_valid", {31'b0, o_valid}, 32'd0);

        // Load mid-batch does not disturb the pending mask.
        req = 32'h0000_0005; load = 1'b1; o_ready = 1'b0;
        step();
        load = 1'b0;
        step();
        check("mid_first_idx", {27'b0, o_idx}, 32'd0);
        req = 32'hFFFF_FFFF; load = 1'b1;
        step();
        load = 1'b0; req = 32'h0; o_ready = 1'b1;
        check("mid_held_idx", {27'b0, o_idx}, 32'd0);
        step();
        $display("[TB] mid-load idx=%0d last=%0b", o_idx, o_last);
        check("mid_second_idx", {27'b0, o_idx}, 32'd2);
        check("mid_second_last", {31'b0, o_last}, 32'd1);
        // Load while busy is about to fall must be ignored too.
        req = 32'h0000_0002; load = 1'b1;
        step();
        load = 1'b0; req = 32'h0;
        step();
        check("fall_load_busy", {31'b0, busy}, 32'd0);
        check("fall_load_valid", {31'b0, o_valid}, 32'd0);

        // Reset mid-batch after three indices.
        req = 32'hFFFF_FFFF; load = 1'b1; o_ready = 1'b1;
        step();
        load = 1'b0; req = 32'h0;
        step(); step();
        step();
        check("rstmid_third_idx", {27'b0, o_idx}, 32'd2);
        reset = 1'b1; load = 1'b1; req = 32'hFFFF_FFFF;
        step();
        reset = 1'b0; load = 1'b0; req = 32'h0;
        $display("[TB] mid-reset valid=%0b idx=%0d last=%0b busy=%0b", o_valid, o_idx, o_last, busy);
        check("rstmid_valid", {31'b0, o_valid}, 32'd0);
        check("rstmid_idx", {27'b0, o_idx}, 32'd0);
        check("rstmid_last", {31'b0, o_last}, 32'd0);
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        step();
        check("rstmid_stale_valid", {31'b0, o_valid}, 32'd0);
        run_batch('{32'h0000_0400, 1, 10, 10});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_encoder32_5_drain
